// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Byte handshake between a host-side byte source and the UART transmitter.
//
//   Signals (named from the transmitter's point of view):
//     i_data        [7:0]  byte offered by the source
//     i_data_valid         source has a byte on i_data
//     o_ready              transmitter can accept a byte this cycle
//
//   Modports:
//     master  - byte source (drives data/valid, observes ready)
//     slave   - transmitter (observes data/valid, drives ready)
// -----------------------------------------------------------------------------
interface uart_tx_if;
    logic [7:0] i_data;
    logic       i_data_valid;
    logic       o_ready;

    modport master (
        output i_data,
        output i_data_valid,
        input  o_ready
    );

    modport slave (
        input  i_data,
        input  i_data_valid,
        output o_ready
    );
endinterface : uart_tx_if

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter: one byte per frame, LSB first, idle-high line.
//   Frame = start bit, 8 data bits, optional parity bit, 1 or 2 stop bits,
//   each bit lasting COUNT_MAX clock cycles.
//
//   Ports:
//     i_clk     system clock, all logic on the rising edge
//     i_rst_n   synchronous active-low reset
//     if_bus    byte handshake (i_data, i_data_valid in; o_ready out)
//     o_tx      serial line, registered, idle high
//     o_busy    a frame is in progress (inverse of o_ready)
//     o_done    one-cycle pulse on the final cycle of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
    parameter int I_CLK_FREQ  = 27_000_000,
    parameter int BAUDRATE    = 115200,
    parameter int COUNTER_LEN = 12,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic     i_clk,
    input  logic     i_rst_n,
    uart_tx_if.slave if_bus,
    output logic     o_tx,
    output logic     o_busy,
    output logic     o_done
);

    localparam int COUNT_MAX = I_CLK_FREQ / BAUDRATE;

    // Out-of-range settings fall back to no parity / one stop bit.
    localparam int PARITY_EFF = (PARITY == 1 || PARITY == 2) ? PARITY : 0;
    localparam int STOP_EFF   = (STOP_BITS == 2) ? 2 : 1;

    localparam logic [COUNTER_LEN-1:0] CNT_LAST  = COUNTER_LEN'(COUNT_MAX - 1);
    localparam logic [2:0]             STOP_LAST = 3'(STOP_EFF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                   r_state;
    logic [COUNTER_LEN-1:0]   r_cnt;
    logic [2:0]               r_bit_idx;
    logic [7:0]               r_shreg;
    logic                     r_parity;
    logic                     r_tx;

    state_t                   w_state_n;
    logic [COUNTER_LEN-1:0]   w_cnt_n;
    logic [2:0]               w_bit_idx_n;
    logic [7:0]               w_shreg_n;
    logic                     w_parity_n;
    logic                     w_tx_n;
    logic                     w_wrap;
    logic                     w_accept;

    assign w_wrap   = (r_cnt == CNT_LAST);
    assign w_accept = (r_state == S_IDLE) && if_bus.i_data_valid;

    // Next-state, next-datapath and next-line-value logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case
        // leaves one unassigned, which would otherwise infer a latch.
        w_state_n   = r_state;
        w_cnt_n     = w_wrap ? '0 : r_cnt + COUNTER_LEN'(1);
        w_bit_idx_n = r_bit_idx;
        w_shreg_n   = r_shreg;
        w_parity_n  = r_parity;

        case (r_state)
            S_IDLE: begin
                w_cnt_n     = '0;
                w_bit_idx_n = '0;
                if (w_accept) begin
                    w_state_n  = S_START;
                    w_shreg_n  = if_bus.i_data;
                    // Even parity is the plain XOR; odd parity inverts it.
                    w_parity_n = (^if_bus.i_data) ^ (PARITY_EFF == 1);
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_n   = S_DATA;
                    w_bit_idx_n = '0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    // Shift so the next data bit sits in shreg[0].
                    w_shreg_n = {1'b0, r_shreg[7:1]};
                    if (r_bit_idx == 3'd7) begin
                        w_bit_idx_n = '0;
                        w_state_n   = (PARITY_EFF != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_n   = S_STOP;
                    w_bit_idx_n = '0;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    if (r_bit_idx == STOP_LAST) begin
                        w_state_n   = S_IDLE;
                        w_bit_idx_n = '0;
                    end else begin
                        w_bit_idx_n = r_bit_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_n   = S_IDLE;
                w_cnt_n     = '0;
                w_bit_idx_n = '0;
            end
        endcase

        // The line is registered, so it is derived from the values the
        // registers will hold after this edge.
        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shreg_n[0];
            S_PARITY: w_tx_n = w_parity_n;
            default:  w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shreg   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_bit_idx <= w_bit_idx_n;
            r_shreg   <= w_shreg_n;
            r_parity  <= w_parity_n;
            r_tx      <= w_tx_n;
        end
    end

    assign if_bus.o_ready = (r_state == S_IDLE);
    assign o_busy         = (r_state != S_IDLE);
    assign o_tx           = r_tx;
    // Last counter cycle of the last stop bit; the FSM returns to IDLE next edge.
    assign o_done         = (r_state == S_STOP) && w_wrap && (r_bit_idx == STOP_LAST);

endmodule : uart_tx

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Five transmitter instances with different framing parameters share one
//   clock and reset; a selector routes the stimulus to one instance at a time
//   and brings its outputs back to the checker. Each frame is compared cycle by
//   cycle against a bit list built from the frame format, and the byte is also
//   recovered by mid-bit sampling as a receiver would.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int N_DUT = 5;

    logic       clk;
    logic       rst_n;
    logic [7:0] tb_data;
    logic       tb_valid;
    int         sel;

    int n_vec;
    int n_err;

    logic obs_tx, obs_busy, obs_done, obs_ready;
    logic tx_v   [N_DUT];
    logic busy_v [N_DUT];
    logic done_v [N_DUT];

    uart_tx_if ifc0 ();
    uart_tx_if ifc1 ();
    uart_tx_if ifc2 ();
    uart_tx_if ifc3 ();
    uart_tx_if ifc4 ();

    assign ifc0.i_data = tb_data;
    assign ifc1.i_data = tb_data;
    assign ifc2.i_data = tb_data;
    assign ifc3.i_data = tb_data;
    assign ifc4.i_data = tb_data;
    assign ifc0.i_data_valid = tb_valid && (sel == 0);
    assign ifc1.i_data_valid = tb_valid && (sel == 1);
    assign ifc2.i_data_valid = tb_valid && (sel == 2);
    assign ifc3.i_data_valid = tb_valid && (sel == 3);
    assign ifc4.i_data_valid = tb_valid && (sel == 4);

    // 8N1, COUNT_MAX = 10
    uart_tx #(.I_CLK_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY(0), .STOP_BITS(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc0.slave),
        .o_tx(tx_v[0]), .o_busy(busy_v[0]), .o_done(done_v[0]));
    // 8E1
    uart_tx #(.I_CLK_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY(2), .STOP_BITS(1)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc1.slave),
        .o_tx(tx_v[1]), .o_busy(busy_v[1]), .o_done(done_v[1]));
    // 8O1
    uart_tx #(.I_CLK_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY(1), .STOP_BITS(1)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc2.slave),
        .o_tx(tx_v[2]), .o_busy(busy_v[2]), .o_done(done_v[2]));
    // 8N2
    uart_tx #(.I_CLK_FREQ(1_000_000), .BAUDRATE(100_000), .PARITY(0), .STOP_BITS(2)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc3.slave),
        .o_tx(tx_v[3]), .o_busy(busy_v[3]), .o_done(done_v[3]));
    // Default parameters, COUNT_MAX = 234
    uart_tx u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .if_bus(ifc4.slave),
        .o_tx(tx_v[4]), .o_busy(busy_v[4]), .o_done(done_v[4]));

    always_comb begin
        obs_tx   = tx_v[0];
        obs_busy = busy_v[0];
        obs_done = done_v[0];
        obs_ready = ifc0.o_ready;
        case (sel)
            1: begin obs_tx = tx_v[1]; obs_busy = busy_v[1]; obs_done = done_v[1]; obs_ready = ifc1.o_ready; end
            2: begin obs_tx = tx_v[2]; obs_busy = busy_v[2]; obs_done = done_v[2]; obs_ready = ifc2.o_ready; end
            3: begin obs_tx = tx_v[3]; obs_busy = busy_v[3]; obs_done = done_v[3]; obs_ready = ifc3.o_ready; end
            4: begin obs_tx = tx_v[4]; obs_busy = busy_v[4]; obs_done = done_v[4]; obs_ready = ifc4.o_ready; end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framing of each instance, mirrored from the parameters above.
    function automatic int cm_of(input int s);
        return (s == 4) ? (27_000_000 / 115200) : (1_000_000 / 100_000);
    endfunction

    function automatic int par_of(input int s);
        case (s)
            1:       return 2;
            2:       return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int stop_of(input int s);
        return (s == 3) ? 2 : 1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (dut %0d, t=%0t): got %0h expected %0h", tag, sel, $time, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic select(input int s);
        sel = s;
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx"},    32'(obs_tx),    32'd1);
        check({tag, "_ready"}, 32'(obs_ready), 32'd1);
        check({tag, "_busy"},  32'(obs_busy),  32'd0);
        check({tag, "_done"},  32'(obs_done),  32'd0);
    endtask

    // Sends byte b on the selected instance and checks the whole frame.
    // hold: keep valid high with nxt on the bus so the next call is back-to-back.
    // abort_at: if nonzero, reset is applied after that frame cycle instead.
    task automatic run_frame(input logic [7:0] b, input logic [7:0] nxt,
                             input bit hold, input int abort_at);
        logic q[$];
        logic [7:0] rx;
        int cm, len, ones, slot;
        logic pbit;

        cm = cm_of(sel);
        q.push_back(1'b0);
        for (int i = 0; i < 8; i++) q.push_back(b[i]);
        if (par_of(sel) != 0) begin
            ones = $countones(b);
            pbit = (ones % 2) == 1;
            if (par_of(sel) == 1) pbit = !pbit;
            q.push_back(pbit);
        end
        for (int i = 0; i < stop_of(sel); i++) q.push_back(1'b1);
        len = cm * q.size();

        check("pre_ready", 32'(obs_ready), 32'd1);
        check("pre_tx",    32'(obs_tx),    32'd1);
        tb_data  = b;
        tb_valid = 1'b1;
        step();
        if (hold) tb_data = nxt;
        else      tb_valid = 1'b0;

        rx = '0;
        for (int k = 1; k <= len; k++) begin
            slot = (k - 1) / cm;
            check("tx",    32'(obs_tx),    32'(q[slot]));
            check("done",  32'(obs_done),  32'(k == len));
            check("ready", 32'(obs_ready), 32'd0);
            check("busy",  32'(obs_busy),  32'd1);
            if (((k - 1) % cm) == cm / 2 && slot >= 1 && slot <= 8) rx[slot-1] = obs_tx;
            if (k == abort_at) begin
                tb_valid = 1'b0;
                rst_n    = 1'b0;
                step();
                rst_n = 1'b1;
                check_idle("abort");
                for (int j = 0; j < 2 * len; j++) begin
                    check("abort_done", 32'(obs_done), 32'd0);
                    check("abort_tx",   32'(obs_tx),   32'd1);
                    step();
                end
                return;
            end
            // Activity on the bus while busy must be ignored.
            if (!hold) begin
                tb_valid = 1'($urandom_range(0, 1));
                tb_data  = 8'($urandom);
            end
            step();
        end
        tb_valid = hold;
        check("post_ready", 32'(obs_ready), 32'd1);
        check("post_busy",  32'(obs_busy),  32'd0);
        check("post_tx",    32'(obs_tx),    32'd1);
        check("post_done",  32'(obs_done),  32'd0);
        check("rx_byte",    32'(rx),        32'(b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_err    = 0;
        sel      = 0;
        tb_data  = '0;
        tb_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int s = 0; s < N_DUT; s++) begin
            select(s);
            check_idle("reset");
        end

        // 8N1: known pattern, random bytes, back-to-back, reset mid-frame.
        select(0);
        step();
        run_frame(8'h55, 8'h00, 1'b0, 0);
        for (int i = 0; i < 4; i++) run_frame(8'($urandom), 8'h00, 1'b0, 0);
        run_frame(8'h01, 8'hFF, 1'b1, 0);
        run_frame(8'hFF, 8'h00, 1'b0, 0);
        // Abort during data bit 3 (frame slot 4).
        run_frame(8'($urandom), 8'h00, 1'b0, 4 * cm_of(0) + 3);
        run_frame(8'hA5, 8'h00, 1'b0, 0);

        // Even parity.
        select(1);
        step();
        run_frame(8'h55, 8'h00, 1'b0, 0);
        run_frame(8'h80, 8'h00, 1'b0, 0);
        for (int i = 0; i < 3; i++) run_frame(8'($urandom), 8'h00, 1'b0, 0);

        // Odd parity.
        select(2);
        step();
        run_frame(8'h55, 8'h00, 1'b0, 0);
        for (int i = 0; i < 2; i++) run_frame(8'($urandom), 8'h00, 1'b0, 0);

        // Two stop bits.
        select(3);
        step();
        run_frame(8'hA3, 8'h00, 1'b0, 0);
        for (int i = 0; i < 2; i++) run_frame(8'($urandom), 8'h00, 1'b0, 0);

        // Default parameters.
        select(4);
        step();
        run_frame(8'h00, 8'h00, 1'b0, 0);
        run_frame(8'hFF, 8'h00, 1'b0, 0);
        run_frame(8'h5A, 8'h00, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_uart_tx
